// File: rtl/one_sched_pkg.sv
//==========================================================================
// one_sched_pkg : shared types and helpers for the one_sched scheduler
// Rev 1.0
//==========================================================================
`default_nettype none

package one_sched_pkg;

    localparam int DEF_W   = 4;
    localparam int DEF_LAT = 2;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [3:0] onehot(input logic [ID_W-1:0] id);
        logic [3:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==========================================================================
// rr_arbiter : combinational round-robin arbiter; pointer register lives in parent
// Rev 1.0
//==========================================================================
`default_nettype none

module rr_arbiter
    import one_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  ptr_next
);

    always_comb begin
        logic found;
        int   idx;
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_next = ID_W'((idx + 1) % N_REQ);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/one_sched.sv
//==========================================================================
// one_sched : round-robin sharing of one `one` datapath among N_REQ requesters
// Rev 1.0
//==========================================================================
`default_nettype none

module one_sched
    import one_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W         = DEF_W,
    parameter int LAT       = DEF_LAT,
    parameter int PIPELINED = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       dp_x,
    input  logic [W-1:0]       dp_y,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_data,
    output logic               busy
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  win_id;
    logic             issue_en;
    logic [3:0]       rsp_onehot;

    // Stages 0..LAT-1 are held here; the response register is the final stage.
    tag_t tags [LAT];

    assign issue_en   = rst_n && ((PIPELINED != 0) || !busy);
    assign gnt        = arb_gnt;
    assign rsp_onehot = onehot(tags[LAT-1].id);

    rr_arbiter #(
        .N_REQ    (N_REQ)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .en       (issue_en),
        .gnt      (arb_gnt),
        .ptr_next (ptr_next)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) win_id = ID_W'(i);
        end
    end

    always_comb begin
        busy = |rsp_valid;
        for (int s = 0; s < LAT; s++) begin
            busy = busy | tags[s].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            dp_x      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int s = 0; s < LAT; s++) begin
                tags[s] <= '0;
            end
        end else begin
            ptr <= ptr_next;
            if (|arb_gnt) begin
                dp_x <= req_data[int'(win_id)*W +: W];
            end
            tags[0].valid <= |arb_gnt;
            tags[0].id    <= win_id;
            for (int s = 1; s < LAT; s++) begin
                tags[s] <= tags[s-1];
            end
            // dp_y is valid in the same cycle the tag reaches stage LAT-1
            if (tags[LAT-1].valid) begin
                rsp_valid <= rsp_onehot[N_REQ-1:0];
                rsp_data  <= dp_y;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_one_sched.sv
//==========================================================================
// tb_one_sched : random-traffic bench for one_sched, pipelined and serial builds
// Rev 1.0
//==========================================================================
`default_nettype none

module tb_one_sched;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int LAT  = 2;
    localparam int NCYC = 1400;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req       [2];
    logic [N*W-1:0] req_data  [2];
    logic [N-1:0]   gnt       [2];
    logic [W-1:0]   dp_x      [2];
    logic [W-1:0]   dp_y      [2];
    logic [N-1:0]   rsp_valid [2];
    logic [W-1:0]   rsp_data  [2];
    logic           busy      [2];

    // Stand-in for the `one` transform: any fixed 4-bit mapping will do.
    function automatic logic [W-1:0] one_ref(input logic [W-1:0] x);
        return {x[2:0], x[3]} ^ 4'b0110;
    endfunction

    // Instance 0 issues every cycle, instance 1 allows one operation in flight.
    for (genvar d = 0; d < 2; d++) begin : g_dut
        one_sched #(
            .N_REQ     (N),
            .W         (W),
            .LAT       (LAT),
            .PIPELINED ((d == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[d]),
            .req_data  (req_data[d]),
            .gnt       (gnt[d]),
            .dp_x      (dp_x[d]),
            .dp_y      (dp_y[d]),
            .rsp_valid (rsp_valid[d]),
            .rsp_data  (rsp_data[d]),
            .busy      (busy[d])
        );

        // LAT=2: one register between dp_x and dp_y
        always_ff @(posedge clk) dp_y[d] <= one_ref(dp_x[d]);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int           m_ptr      [2];
    int           max_due    [2];
    logic [W-1:0] m_dpx      [2];
    logic [W-1:0] m_rsp_data [2];
    logic [N-1:0] ex_rv      [2][NCYC];
    logic [W-1:0] ex_rd      [2][NCYC];
    logic [N-1:0] pend       [2];
    logic [W-1:0] op         [2][N];
    int           load;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit do_rst);
        int  win;
        int  due;
        bit  allowed;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !do_rst;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[d][i] && $urandom_range(0, 24) == 0) begin
                    pend[d][i] = 1'b0;
                end else if (!pend[d][i] && $urandom_range(0, 99) < load) begin
                    pend[d][i] = 1'b1;
                    op[d][i]   = W'($urandom);
                end
            end
            req[d] = pend[d];
            for (int i = 0; i < N; i++) req_data[d][i*W +: W] = op[d][i];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dp_x[%0d]", d), 32'(dp_x[d]), 32'(m_dpx[d]));
            if (ex_rv[d][cyc] != '0) m_rsp_data[d] = ex_rd[d][cyc];
            chk($sformatf("rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'(ex_rv[d][cyc]));
            chk($sformatf("rsp_data[%0d]", d), 32'(rsp_data[d]), 32'(m_rsp_data[d]));
            chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(cyc <= max_due[d]));

            allowed = !do_rst && (d == 0 || cyc > max_due[d]);
            win = -1;
            if (allowed) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && pend[d][(m_ptr[d] + k) % N]) win = (m_ptr[d] + k) % N;
                end
            end
            chk($sformatf("gnt[%0d]", d), 32'(gnt[d]), (win >= 0) ? (32'(1) << win) : 32'(0));

            if (win >= 0) begin
                due          = cyc + LAT + 1;
                m_ptr[d]     = (win + 1) % N;
                m_dpx[d]     = op[d][win];
                ex_rv[d][due] = N'(1 << win);
                ex_rd[d][due] = one_ref(op[d][win]);
                max_due[d]   = due;
                pend[d][win] = 1'b0;
            end
            if (do_rst) begin
                m_ptr[d]      = 0;
                m_dpx[d]      = '0;
                m_rsp_data[d] = '0;
                for (int c = cyc + 1; c <= cyc + LAT + 1; c++) ex_rv[d][c] = '0;
                max_due[d]    = cyc;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 60;
        for (int d = 0; d < 2; d++) begin
            req[d]        = '0;
            req_data[d]   = '0;
            pend[d]       = '0;
            m_ptr[d]      = 0;
            max_due[d]    = 0;
            m_dpx[d]      = '0;
            m_rsp_data[d] = '0;
            for (int i = 0; i < N; i++) op[d][i] = '0;
            for (int c = 0; c < NCYC; c++) begin
                ex_rv[d][c] = '0;
                ex_rd[d][c] = '0;
            end
        end
        repeat (2) @(posedge clk);

        repeat (3) step(1'b1);
        for (int c = 0; c < 1300; c++) begin
            if (c % 300 == 0) load = $urandom_range(10, 100);
            step(c == 400 || c == 401 || c == 900);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
